// File: rtl/rvh_lsu_pkg.sv
// Shared types for the LSU load request issue queue.
//   ROB_TAG_WIDTH / PREG_TAG_WIDTH / REQ_TYPE_WIDTH / VADDR_WIDTH : payload widths
//   ld_iq_state_e : per-entry lifecycle (IDLE -> WAIT_ISSUE -> INFLIGHT)
//   ld_iq_entry_t : one queue entry (state + payload carried to L1D)
package rvh_lsu_pkg;

  localparam int ROB_TAG_WIDTH  = 4;
  localparam int PREG_TAG_WIDTH = 6;
  localparam int REQ_TYPE_WIDTH = 15;
  localparam int VADDR_WIDTH    = 39;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_ISSUE = 2'd1,
    INFLIGHT   = 2'd2
  } ld_iq_state_e;

  typedef struct packed {
    ld_iq_state_e                state;
    logic [ROB_TAG_WIDTH-1:0]    rob_tag;
    logic [PREG_TAG_WIDTH-1:0]   prd;
    logic [REQ_TYPE_WIDTH-1:0]   req_type;
    logic [VADDR_WIDTH-1:0]      vaddr;
  } ld_iq_entry_t;

endpackage

// File: rtl/rvh_lsu_ld_req_issue_q_if.sv
// L1D bank load request port.
//   vld      : request valid (issue queue -> L1D)
//   rdy      : L1D accepts   (L1D -> issue queue)
//   rob_tag, prd, req_type, vaddr : request payload (L1D uses vaddr[5:0] as offset)
// Handshake: a request transfers on a cycle where vld && rdy. Once vld is
// raised without rdy, vld and the whole payload hold unchanged until the
// transfer happens (or the queue is flushed); rdy may toggle freely.
interface rvh_lsu_ld_req_issue_q_if import rvh_lsu_pkg::*; ;
  logic                        vld;
  logic                        rdy;
  logic [ROB_TAG_WIDTH-1:0]    rob_tag;
  logic [PREG_TAG_WIDTH-1:0]   prd;
  logic [REQ_TYPE_WIDTH-1:0]   req_type;
  logic [VADDR_WIDTH-1:0]      vaddr;

  modport master (output vld, rob_tag, prd, req_type, vaddr, input rdy);
  modport slave  (input vld, rob_tag, prd, req_type, vaddr, output rdy);
endinterface

// File: rtl/rvh_lsu_age_matrix.sv
// Age matrix for relative ordering of queue entries.
//   alloc_i   : one-hot, entry becoming the youngest this cycle
//   dealloc_i : entries leaving the queue (any number)
//   req_i     : candidate entries
//   oldest_o  : one-hot oldest candidate (all zero when req_i is zero)
// age_q[i][j] = 1 means entry i is older than entry j. For any two live
// entries exactly one of the pair bits is set, written when the younger one
// was allocated.
module rvh_lsu_age_matrix #(
  parameter int ENTRY_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ENTRY_COUNT-1:0] alloc_i,
  input  logic [ENTRY_COUNT-1:0] dealloc_i,
  input  logic [ENTRY_COUNT-1:0] req_i,
  output logic [ENTRY_COUNT-1:0] oldest_o
);

  logic [ENTRY_COUNT-1:0][ENTRY_COUNT-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      for (int j = 0; j < ENTRY_COUNT; j++) begin
        if (i != j) begin
          if (dealloc_i[i] || dealloc_i[j]) age_d[i][j] = 1'b0;
          // Everyone already present is older than the newcomer.
          if (alloc_i[j]) age_d[i][j] = 1'b1;
          if (alloc_i[i]) age_d[i][j] = 1'b0;
        end
      end
    end
  end

  // An entry is oldest if no other requester is older than it.
  always_comb begin
    oldest_o = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      oldest_o[i] = req_i[i];
      for (int j = 0; j < ENTRY_COUNT; j++) begin
        if ((i != j) && req_i[j] && !age_q[i][j]) oldest_o[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= '0;
    else        age_q <= age_d;
  end

endmodule

// File: rtl/rvh_lsu_ld_req_issue_q.sv
// Load request issue queue between LSU dispatch and the L1D bank load port.
//   clk, rst_n          : clock, async active-low reset
//   flush_i             : drop every entry (wins over all other events)
//   enq_*               : dispatch enqueue (enq_rdy_o from registered state)
//   ls_pipe_l1d_ld_req  : L1D request port (master side), oldest-first issue
//   l1d_rob_wb_*        : completion, frees the matching INFLIGHT entry
//   l1d_ld_replay_*     : rejection, returns matching INFLIGHT entry to WAIT_ISSUE
//   outstanding_cnt_o   : registered count of non-IDLE entries
// Per-entry FSM state lives in entries_q[i].state.
module rvh_lsu_ld_req_issue_q import rvh_lsu_pkg::*; #(
  parameter int ENTRY_COUNT = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            enq_vld_i,
  output logic                            enq_rdy_o,
  input  logic [ROB_TAG_WIDTH-1:0]        enq_rob_tag_i,
  input  logic [PREG_TAG_WIDTH-1:0]       enq_prd_i,
  input  logic [REQ_TYPE_WIDTH-1:0]       enq_req_type_i,
  input  logic [VADDR_WIDTH-1:0]          enq_vaddr_i,
  rvh_lsu_ld_req_issue_q_if.master        ls_pipe_l1d_ld_req,
  input  logic                            l1d_rob_wb_vld_i,
  input  logic [ROB_TAG_WIDTH-1:0]        l1d_rob_wb_rob_tag_i,
  input  logic                            l1d_ld_replay_vld_i,
  input  logic [ROB_TAG_WIDTH-1:0]        l1d_ld_replay_rob_tag_i,
  output logic [$clog2(ENTRY_COUNT):0]    outstanding_cnt_o
);

  localparam int CNT_W = $clog2(ENTRY_COUNT) + 1;

  ld_iq_entry_t           entries_q [ENTRY_COUNT];
  ld_iq_entry_t           entries_d [ENTRY_COUNT];
  logic                   lock_q, lock_d;
  logic [ENTRY_COUNT-1:0] lock_sel_q, lock_sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [ENTRY_COUNT-1:0] idle_vec, wait_vec, oldest_vec, sel_vec;
  logic [ENTRY_COUNT-1:0] free_vec, alloc_oh, wb_hit, replay_hit, dealloc_vec;
  logic                   enq_fire, req_vld, req_fire;

  always_comb begin
    idle_vec   = '0;
    wait_vec   = '0;
    wb_hit     = '0;
    replay_hit = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      idle_vec[i]   = (entries_q[i].state == IDLE);
      wait_vec[i]   = (entries_q[i].state == WAIT_ISSUE);
      wb_hit[i]     = l1d_rob_wb_vld_i && (entries_q[i].state == INFLIGHT) &&
                      (entries_q[i].rob_tag == l1d_rob_wb_rob_tag_i);
      replay_hit[i] = l1d_ld_replay_vld_i && (entries_q[i].state == INFLIGHT) &&
                      (entries_q[i].rob_tag == l1d_ld_replay_rob_tag_i);
    end
  end

  // Lowest-index IDLE entry takes the next enqueue.
  always_comb begin
    free_vec = '0;
    for (int i = ENTRY_COUNT - 1; i >= 0; i--) begin
      if (idle_vec[i]) begin
        free_vec    = '0;
        free_vec[i] = 1'b1;
      end
    end
  end

  assign enq_rdy_o = |idle_vec;
  assign enq_fire  = enq_vld_i && enq_rdy_o && !flush_i;
  assign alloc_oh  = enq_fire ? free_vec : '0;

  rvh_lsu_age_matrix #(.ENTRY_COUNT(ENTRY_COUNT)) u_age_matrix (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc_i   (alloc_oh),
    .dealloc_i (dealloc_vec),
    .req_i     (wait_vec),
    .oldest_o  (oldest_vec)
  );

  // A stalled request keeps its entry even if an older one gets replayed.
  assign sel_vec  = lock_q ? lock_sel_q : oldest_vec;
  assign req_vld  = |sel_vec;
  assign req_fire = req_vld && ls_pipe_l1d_ld_req.rdy;

  assign dealloc_vec = flush_i ? {ENTRY_COUNT{1'b1}} : wb_hit;

  // One-hot AND-OR payload mux; all-zero select yields all-zero payload.
  always_comb begin
    ls_pipe_l1d_ld_req.rob_tag  = '0;
    ls_pipe_l1d_ld_req.prd      = '0;
    ls_pipe_l1d_ld_req.req_type = '0;
    ls_pipe_l1d_ld_req.vaddr    = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (sel_vec[i]) begin
        ls_pipe_l1d_ld_req.rob_tag  = ls_pipe_l1d_ld_req.rob_tag  | entries_q[i].rob_tag;
        ls_pipe_l1d_ld_req.prd      = ls_pipe_l1d_ld_req.prd      | entries_q[i].prd;
        ls_pipe_l1d_ld_req.req_type = ls_pipe_l1d_ld_req.req_type | entries_q[i].req_type;
        ls_pipe_l1d_ld_req.vaddr    = ls_pipe_l1d_ld_req.vaddr    | entries_q[i].vaddr;
      end
    end
  end

  assign ls_pipe_l1d_ld_req.vld = req_vld;

  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (flush_i) begin
        entries_d[i].state = IDLE;
      end else begin
        case (entries_q[i].state)
          IDLE: begin
            if (alloc_oh[i]) begin
              entries_d[i].state    = WAIT_ISSUE;
              entries_d[i].rob_tag  = enq_rob_tag_i;
              entries_d[i].prd      = enq_prd_i;
              entries_d[i].req_type = enq_req_type_i;
              entries_d[i].vaddr    = enq_vaddr_i;
            end
          end
          WAIT_ISSUE: if (req_fire && sel_vec[i]) entries_d[i].state = INFLIGHT;
          // Writeback takes priority over a same-tag replay.
          INFLIGHT: begin
            if (wb_hit[i])          entries_d[i].state = IDLE;
            else if (replay_hit[i]) entries_d[i].state = WAIT_ISSUE;
          end
          default: entries_d[i].state = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    lock_d     = req_vld && !ls_pipe_l1d_ld_req.rdy && !flush_i;
    lock_sel_d = sel_vec;
    cnt_d      = '0;
    for (int i = 0; i < ENTRY_COUNT; i++) begin
      if (entries_d[i].state != IDLE) cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_COUNT; i++) entries_q[i] <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      cnt_q      <= '0;
    end else begin
      for (int i = 0; i < ENTRY_COUNT; i++) entries_q[i] <= entries_d[i];
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign outstanding_cnt_o = cnt_q;

endmodule

// File: tb/tb_rvh_lsu_ld_req_issue_q.sv
module tb_rvh_lsu_ld_req_issue_q;
  import rvh_lsu_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        flush_i;
  logic                        enq_vld_i;
  logic                        enq_rdy_o;
  logic [ROB_TAG_WIDTH-1:0]    enq_rob_tag_i;
  logic [PREG_TAG_WIDTH-1:0]   enq_prd_i;
  logic [REQ_TYPE_WIDTH-1:0]   enq_req_type_i;
  logic [VADDR_WIDTH-1:0]      enq_vaddr_i;
  logic                        wb_vld;
  logic [ROB_TAG_WIDTH-1:0]    wb_tag;
  logic                        rep_vld;
  logic [ROB_TAG_WIDTH-1:0]    rep_tag;
  logic [2:0]                  cnt;

  int checks = 0;
  int errors = 0;

  rvh_lsu_ld_req_issue_q_if ld_if ();

  rvh_lsu_ld_req_issue_q #(.ENTRY_COUNT(4)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .flush_i                 (flush_i),
    .enq_vld_i               (enq_vld_i),
    .enq_rdy_o               (enq_rdy_o),
    .enq_rob_tag_i           (enq_rob_tag_i),
    .enq_prd_i               (enq_prd_i),
    .enq_req_type_i          (enq_req_type_i),
    .enq_vaddr_i             (enq_vaddr_i),
    .ls_pipe_l1d_ld_req      (ld_if.master),
    .l1d_rob_wb_vld_i        (wb_vld),
    .l1d_rob_wb_rob_tag_i    (wb_tag),
    .l1d_ld_replay_vld_i     (rep_vld),
    .l1d_ld_replay_rob_tag_i (rep_tag),
    .outstanding_cnt_o       (cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Payload generated from the rob tag so every request is identifiable.
  function automatic logic [PREG_TAG_WIDTH-1:0] pay_prd(input logic [3:0] t);
    return {2'b10, t};
  endfunction
  function automatic logic [REQ_TYPE_WIDTH-1:0] pay_type(input logic [3:0] t);
    return 15'h1 << t;
  endfunction
  function automatic logic [VADDR_WIDTH-1:0] pay_vaddr(input logic [3:0] t);
    return 39'h12_3456_7000 + {35'h0, t};
  endfunction

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    flush_i        = 1'b0;
    enq_vld_i      = 1'b0;
    enq_rob_tag_i  = '0;
    enq_prd_i      = '0;
    enq_req_type_i = '0;
    enq_vaddr_i    = '0;
    wb_vld         = 1'b0;
    wb_tag         = '0;
    rep_vld        = 1'b0;
    rep_tag        = '0;
    ld_if.rdy      = 1'b0;
  endtask

  task automatic drive_enq(input logic [3:0] t);
    enq_vld_i      = 1'b1;
    enq_rob_tag_i  = t;
    enq_prd_i      = pay_prd(t);
    enq_req_type_i = pay_type(t);
    enq_vaddr_i    = pay_vaddr(t);
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (cnt !== 3'd0 || ld_if.vld !== 1'b0 || enq_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: cnt=%0d vld=%0b rdy=%0b, expected cnt=0 vld=0 rdy=1", cnt, ld_if.vld, enq_rdy_o);
    end
    checks++;
    if (ld_if.rob_tag !== '0 || ld_if.prd !== '0 || ld_if.req_type !== '0 || ld_if.vaddr !== '0) begin
      errors++;
      $display("FAIL reset_payload: tag=%0h prd=%0h type=%0h vaddr=%0h, expected all 0",
               ld_if.rob_tag, ld_if.prd, ld_if.req_type, ld_if.vaddr);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (cnt !== 3'd0 || ld_if.vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cnt=%0d vld=%0b, expected cnt=0 vld=0", cnt, ld_if.vld);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] tags [3];
    logic [2:0] cnts [3];
    tags = '{4'd1, 4'd2, 4'd3};
    clear_inputs();
    ld_if.rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_enq(tags[k]);
      tick();
      checks++;
      if (ld_if.vld !== 1'b1 || ld_if.rob_tag !== tags[k] || cnt !== 3'(k + 1)) begin
        errors++;
        $display("FAIL b2b_issue_%0d: vld=%0b tag=%0d cnt=%0d, expected vld=1 tag=%0d cnt=%0d",
                 k, ld_if.vld, ld_if.rob_tag, cnt, tags[k], k + 1);
      end
      checks++;
      if (ld_if.prd !== pay_prd(tags[k]) || ld_if.req_type !== pay_type(tags[k]) ||
          ld_if.vaddr !== pay_vaddr(tags[k])) begin
        errors++;
        $display("FAIL b2b_payload_%0d: prd=%0h type=%0h vaddr=%0h, expected prd=%0h type=%0h vaddr=%0h",
                 k, ld_if.prd, ld_if.req_type, ld_if.vaddr, pay_prd(tags[k]), pay_type(tags[k]), pay_vaddr(tags[k]));
      end
    end
    enq_vld_i = 1'b0;
    tick();
    checks++;
    if (ld_if.vld !== 1'b0 || cnt !== 3'd3) begin
      errors++;
      $display("FAIL b2b_drained: vld=%0b cnt=%0d, expected vld=0 cnt=3", ld_if.vld, cnt);
    end
    ld_if.rdy = 1'b0;
    tags = '{4'd2, 4'd1, 4'd3};
    cnts = '{3'd2, 3'd1, 3'd0};
    wb_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wb_tag = tags[k];
      tick();
      checks++;
      if (cnt !== cnts[k]) begin
        errors++;
        $display("FAIL b2b_wb_tag%0d: cnt=%0d, expected %0d", tags[k], cnt, cnts[k]);
      end
    end
    wb_vld = 1'b0;
  endtask

  task automatic test_full_wb;
    logic [3:0] drain [3];
    clear_inputs();
    for (int k = 5; k <= 8; k++) begin
      drive_enq(4'(k));
      tick();
    end
    enq_vld_i = 1'b0;
    checks++;
    if (cnt !== 3'd4 || enq_rdy_o !== 1'b0 || ld_if.vld !== 1'b1 || ld_if.rob_tag !== 4'd5) begin
      errors++;
      $display("FAIL full_state: cnt=%0d rdy=%0b vld=%0b tag=%0d, expected cnt=4 rdy=0 vld=1 tag=5",
               cnt, enq_rdy_o, ld_if.vld, ld_if.rob_tag);
    end
    ld_if.rdy = 1'b1;
    tick();
    ld_if.rdy = 1'b0;
    checks++;
    if (ld_if.rob_tag !== 4'd6 || ld_if.vld !== 1'b1) begin
      errors++;
      $display("FAIL full_next_issue: vld=%0b tag=%0d, expected vld=1 tag=6", ld_if.vld, ld_if.rob_tag);
    end
    // wb tag 5 while full; an enq attempt in the same cycle must be refused.
    wb_vld = 1'b1;
    wb_tag = 4'd5;
    drive_enq(4'd12);
    tick();
    wb_vld = 1'b0;
    checks++;
    if (enq_rdy_o !== 1'b1 || cnt !== 3'd3) begin
      errors++;
      $display("FAIL full_wb_free: rdy=%0b cnt=%0d, expected rdy=1 cnt=3", enq_rdy_o, cnt);
    end
    drive_enq(4'd9);
    tick();
    enq_vld_i = 1'b0;
    checks++;
    if (cnt !== 3'd4 || enq_rdy_o !== 1'b0 || dut.entries_q[0].rob_tag !== 4'd9 ||
        dut.entries_q[0].state !== WAIT_ISSUE) begin
      errors++;
      $display("FAIL full_reuse_slot0: cnt=%0d rdy=%0b slot0_tag=%0d, expected cnt=4 rdy=0 slot0_tag=9",
               cnt, enq_rdy_o, dut.entries_q[0].rob_tag);
    end
    checks++;
    if (ld_if.rob_tag !== 4'd6) begin
      errors++;
      $display("FAIL full_lock_hold: tag=%0d, expected 6", ld_if.rob_tag);
    end
    drain = '{4'd7, 4'd8, 4'd9};
    ld_if.rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ld_if.vld !== 1'b1 || ld_if.rob_tag !== drain[k]) begin
        errors++;
        $display("FAIL full_drain_%0d: vld=%0b tag=%0d, expected vld=1 tag=%0d", k, ld_if.vld, ld_if.rob_tag, drain[k]);
      end
    end
    tick();
    ld_if.rdy = 1'b0;
    wb_vld = 1'b1;
    for (int k = 6; k <= 9; k++) begin
      wb_tag = 4'(k);
      tick();
    end
    wb_vld = 1'b0;
    checks++;
    if (cnt !== 3'd0 || ld_if.vld !== 1'b0) begin
      errors++;
      $display("FAIL full_empty: cnt=%0d vld=%0b, expected cnt=0 vld=0", cnt, ld_if.vld);
    end
  endtask

  task automatic test_replay_lock;
    clear_inputs();
    drive_enq(4'd1);
    tick();
    drive_enq(4'd2);
    ld_if.rdy = 1'b1;
    tick();
    enq_vld_i = 1'b0;
    ld_if.rdy = 1'b0;
    tick();
    rep_vld = 1'b1;
    rep_tag = 4'd1;
    tick();
    rep_vld = 1'b0;
    checks++;
    if (ld_if.vld !== 1'b1 || ld_if.rob_tag !== 4'd2 || ld_if.prd !== pay_prd(4'd2)) begin
      errors++;
      $display("FAIL replay_locked: vld=%0b tag=%0d prd=%0h, expected vld=1 tag=2 prd=%0h",
               ld_if.vld, ld_if.rob_tag, ld_if.prd, pay_prd(4'd2));
    end
    tick();
    checks++;
    if (ld_if.rob_tag !== 4'd2) begin
      errors++;
      $display("FAIL replay_locked_again: tag=%0d, expected 2", ld_if.rob_tag);
    end
    ld_if.rdy = 1'b1;
    tick();
    checks++;
    if (ld_if.vld !== 1'b1 || ld_if.rob_tag !== 4'd1) begin
      errors++;
      $display("FAIL replay_reissue: vld=%0b tag=%0d, expected vld=1 tag=1", ld_if.vld, ld_if.rob_tag);
    end
    tick();
    ld_if.rdy = 1'b0;
    checks++;
    if (ld_if.vld !== 1'b0 || cnt !== 3'd2) begin
      errors++;
      $display("FAIL replay_done: vld=%0b cnt=%0d, expected vld=0 cnt=2", ld_if.vld, cnt);
    end
    wb_vld = 1'b1;
    wb_tag = 4'd1;
    tick();
    wb_tag = 4'd2;
    tick();
    wb_vld = 1'b0;
    checks++;
    if (cnt !== 3'd0) begin
      errors++;
      $display("FAIL replay_empty: cnt=%0d, expected 0", cnt);
    end
  endtask

  task automatic test_wb_replay_same;
    clear_inputs();
    ld_if.rdy = 1'b1;
    drive_enq(4'd4);
    tick();
    enq_vld_i = 1'b0;
    tick();
    ld_if.rdy = 1'b0;
    checks++;
    if (cnt !== 3'd1 || ld_if.vld !== 1'b0) begin
      errors++;
      $display("FAIL wbrep_inflight: cnt=%0d vld=%0b, expected cnt=1 vld=0", cnt, ld_if.vld);
    end
    wb_vld  = 1'b1;
    wb_tag  = 4'd4;
    rep_vld = 1'b1;
    rep_tag = 4'd4;
    tick();
    wb_vld  = 1'b0;
    rep_vld = 1'b0;
    checks++;
    if (cnt !== 3'd0 || ld_if.vld !== 1'b0) begin
      errors++;
      $display("FAIL wbrep_wb_wins: cnt=%0d vld=%0b, expected cnt=0 vld=0", cnt, ld_if.vld);
    end
    tick();
    checks++;
    if (ld_if.vld !== 1'b0) begin
      errors++;
      $display("FAIL wbrep_no_reissue: vld=%0b, expected 0", ld_if.vld);
    end
    ld_if.rdy = 1'b1;
    drive_enq(4'd3);
    tick();
    enq_vld_i = 1'b0;
    tick();
    ld_if.rdy = 1'b0;
    wb_vld = 1'b1;
    wb_tag = 4'd9;
    tick();
    wb_vld = 1'b0;
    checks++;
    if (cnt !== 3'd1 || dut.entries_q[0].state !== INFLIGHT) begin
      errors++;
      $display("FAIL wb_not_live: cnt=%0d state=%0d, expected cnt=1 state=2", cnt, dut.entries_q[0].state);
    end
    rep_vld = 1'b1;
    rep_tag = 4'd9;
    tick();
    rep_vld = 1'b0;
    checks++;
    if (ld_if.vld !== 1'b0 || cnt !== 3'd1) begin
      errors++;
      $display("FAIL replay_not_live: vld=%0b cnt=%0d, expected vld=0 cnt=1", ld_if.vld, cnt);
    end
    wb_vld = 1'b1;
    wb_tag = 4'd3;
    tick();
    wb_vld = 1'b0;
    checks++;
    if (cnt !== 3'd0) begin
      errors++;
      $display("FAIL wbrep_empty: cnt=%0d, expected 0", cnt);
    end
  endtask

  task automatic test_flush;
    clear_inputs();
    drive_enq(4'd1);
    tick();
    drive_enq(4'd2);
    ld_if.rdy = 1'b1;
    tick();
    enq_vld_i = 1'b0;
    ld_if.rdy = 1'b0;
    tick();
    checks++;
    if (ld_if.rob_tag !== 4'd2 || cnt !== 3'd2) begin
      errors++;
      $display("FAIL flush_setup: tag=%0d cnt=%0d, expected tag=2 cnt=2", ld_if.rob_tag, cnt);
    end
    flush_i = 1'b1;
    drive_enq(4'd3);
    ld_if.rdy = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (cnt !== 3'd0 || ld_if.vld !== 1'b0 || enq_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: cnt=%0d vld=%0b rdy=%0b, expected cnt=0 vld=0 rdy=1", cnt, ld_if.vld, enq_rdy_o);
    end
    wb_vld = 1'b1;
    wb_tag = 4'd1;
    tick();
    wb_vld  = 1'b0;
    rep_vld = 1'b1;
    rep_tag = 4'd1;
    tick();
    rep_vld = 1'b0;
    checks++;
    if (cnt !== 3'd0 || ld_if.vld !== 1'b0) begin
      errors++;
      $display("FAIL flush_late_wb: cnt=%0d vld=%0b, expected cnt=0 vld=0", cnt, ld_if.vld);
    end
    drive_enq(4'd5);
    tick();
    enq_vld_i = 1'b0;
    checks++;
    if (ld_if.vld !== 1'b1 || ld_if.rob_tag !== 4'd5 || cnt !== 3'd1) begin
      errors++;
      $display("FAIL flush_unlock: vld=%0b tag=%0d cnt=%0d, expected vld=1 tag=5 cnt=1", ld_if.vld, ld_if.rob_tag, cnt);
    end
    ld_if.rdy = 1'b1;
    tick();
    ld_if.rdy = 1'b0;
    wb_vld = 1'b1;
    wb_tag = 4'd5;
    tick();
    wb_vld = 1'b0;
    checks++;
    if (cnt !== 3'd0) begin
      errors++;
      $display("FAIL flush_empty: cnt=%0d, expected 0", cnt);
    end
  endtask

  task automatic test_reset_mid;
    clear_inputs();
    for (int k = 1; k <= 3; k++) begin
      drive_enq(4'(k));
      tick();
    end
    enq_vld_i = 1'b0;
    checks++;
    if (cnt !== 3'd3 || ld_if.vld !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup: cnt=%0d vld=%0b, expected cnt=3 vld=1", cnt, ld_if.vld);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (cnt !== 3'd0 || ld_if.vld !== 1'b0 || enq_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_clear: cnt=%0d vld=%0b rdy=%0b, expected cnt=0 vld=0 rdy=1", cnt, ld_if.vld, enq_rdy_o);
    end
    rst_n = 1'b1;
    drive_enq(4'd7);
    tick();
    enq_vld_i = 1'b0;
    checks++;
    if (ld_if.vld !== 1'b1 || ld_if.rob_tag !== 4'd7 || cnt !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_after: vld=%0b tag=%0d cnt=%0d, expected vld=1 tag=7 cnt=1", ld_if.vld, ld_if.rob_tag, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_wb();
    test_replay_lock();
    test_wb_replay_same();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
